// File: rtl/led_step_sequencer.sv
// led_step_sequencer: loadable LED frame sequence, played back cyclically
// one frame per prescaled tick.
//
// Ports:
//   CLK, RST     clock; synchronous active-high reset
//   load_valid   a load beat is presented
//   load_ready   beats accepted (idle and not asked to run)
//   load_frame   frame data for the current beat
//   load_last    final beat of the sequence
//   run          level: 1 = play, 0 = stop
//   frame_out    current LED frame (registered)
//   frame_valid  one-cycle strobe whenever frame_out is updated
//   seq_len      number of frames currently stored
//   busy         high while playing
module led_step_sequencer #(
    parameter int TICK_DIV = 1200000,
    parameter int LED_W    = 5,
    parameter int DEPTH    = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [LED_W-1:0]       load_frame,
    input  logic                   load_last,
    input  logic                   run,
    output logic [LED_W-1:0]       frame_out,
    output logic                   frame_valid,
    output logic [$clog2(DEPTH):0] seq_len,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] TC      = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] WR_END  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] A_ONE   = AW'(1);
    localparam logic [AW:0]   L_ONE   = (AW + 1)'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [PW-1:0]     prescaler;
    logic [LED_W-1:0]  mem [DEPTH];

    logic              accept;
    logic              wr_final;
    logic              tick;
    logic [AW:0]       wr_count;
    logic [AW-1:0]     rd_next;
    logic [AW-1:0]     rd_first;

    assign load_ready = (state == IDLE) && !run;
    assign accept     = load_valid && load_ready;

    // A full memory closes the sequence even without load_last.
    assign wr_final   = load_last || (wr_ptr == WR_END);
    assign wr_count   = {1'b0, wr_ptr} + L_ONE;

    assign tick       = (prescaler == TC);

    // Read pointer wraps on the stored length, not on DEPTH.
    assign rd_next    = ({1'b0, rd_ptr} == (seq_len - L_ONE)) ? '0
                                                              : rd_ptr + A_ONE;
    assign rd_first   = (seq_len == L_ONE) ? '0 : A_ONE;

    always_ff @(posedge CLK) begin
        if (accept && !RST) begin
            mem[wr_ptr] <= load_frame;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            seq_len     <= '0;
            busy        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            prescaler   <= '0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (wr_final) begin
                            seq_len <= wr_count;
                            wr_ptr  <= '0;
                        end else begin
                            wr_ptr  <= wr_ptr + A_ONE;
                        end
                    end
                    // First frame is issued on the start edge itself.
                    if (run && (seq_len != '0)) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        rd_ptr      <= rd_first;
                        prescaler   <= '0;
                        frame_out   <= mem[0];
                        frame_valid <= 1'b1;
                    end
                end
                RUN: begin
                    // Stop wins over a coincident terminal count.
                    if (!run) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        rd_ptr      <= '0;
                        prescaler   <= '0;
                        frame_out   <= '0;
                        frame_valid <= 1'b1;
                    end else if (tick) begin
                        prescaler   <= '0;
                        rd_ptr      <= rd_next;
                        frame_out   <= mem[rd_ptr];
                        frame_valid <= 1'b1;
                    end else begin
                        prescaler   <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_step_sequencer.sv
// tb_led_step_sequencer: directed plus randomized bench for
// led_step_sequencer, checked every cycle against a behavioural model.
module tb_led_step_sequencer;

    localparam int TICK_DIV = 4;
    localparam int LED_W    = 5;
    localparam int DEPTH    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [LED_W-1:0] load_frame;
    logic             load_last;
    logic             run;
    logic [LED_W-1:0] frame_out;
    logic             frame_valid;
    logic [2:0]       seq_len;
    logic             busy;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    led_step_sequencer #(
        .TICK_DIV (TICK_DIV),
        .LED_W    (LED_W),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_frame  (load_frame),
        .load_last   (load_last),
        .run         (run),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .seq_len     (seq_len),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: playback is expressed as elapsed cycles since
    // start, frame index = (elapsed / TICK_DIV) mod length.
    logic [LED_W-1:0] m_mem [DEPTH];
    int               m_len   = 0;
    int               m_wr    = 0;
    int               m_k     = 0;
    bit               m_play  = 1'b0;
    logic [LED_W-1:0] e_frame = '0;
    logic             e_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_len   = 0;
            m_wr    = 0;
            m_k     = 0;
            m_play  = 1'b0;
            e_frame = '0;
            e_valid = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (m_play) begin
                if (!run) begin
                    m_play  = 1'b0;
                    e_frame = '0;
                    e_valid = 1'b1;
                end else begin
                    m_k = m_k + 1;
                    if (m_k % TICK_DIV == 0) begin
                        e_frame = m_mem[(m_k / TICK_DIV) % m_len];
                        e_valid = 1'b1;
                    end
                end
            end else begin
                if (load_valid && !run) begin
                    m_mem[m_wr] = load_frame;
                    if (load_last || m_wr == DEPTH - 1) begin
                        m_len = m_wr + 1;
                        m_wr  = 0;
                    end else begin
                        m_wr = m_wr + 1;
                    end
                end
                if (run && m_len != 0) begin
                    m_play  = 1'b1;
                    m_k     = 0;
                    e_frame = m_mem[0];
                    e_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("frame_out", 32'(frame_out), 32'(e_frame));
            chk("frame_valid", 32'(frame_valid), 32'(e_valid));
            chk("busy", 32'(busy), 32'(m_play));
            chk("seq_len", 32'(seq_len), 32'(m_len));
            chk("load_ready", 32'(load_ready), 32'(!m_play && !run));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [LED_W-1:0] f, input logic last);
        load_valid = 1'b1;
        load_frame = f;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic want_frame(input string name, input logic [LED_W-1:0] f);
        chk({name, "_valid"}, 32'(frame_valid), 32'd1);
        chk(name, 32'(frame_out), 32'(f));
    endtask

    task automatic stop_run();
        run = 1'b0;
        step();
        want_frame("blank", 5'h00);
        chk("blank_busy", 32'(busy), 32'd0);
    endtask

    logic [LED_W-1:0] seq_a [5];

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_frame = '0;
        load_last  = 1'b0;
        run        = 1'b0;
        seq_a      = '{5'h01, 5'h02, 5'h1F, 5'h01, 5'h02};
        step();
        chk_on = 1'b1;
        rst    = 1'b0;
        chk("rst_seq_len", 32'(seq_len), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_frame", 32'(frame_out), 32'd0);
        step();

        // run with nothing stored
        run = 1'b1;
        repeat (6) step();
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_ready", 32'(load_ready), 32'd0);
        chk("empty_valid", 32'(frame_valid), 32'd0);
        run = 1'b0;
        step();

        // three-frame sequence
        beat(5'h01, 1'b0);
        beat(5'h02, 1'b0);
        beat(5'h1F, 1'b1);
        chk("len3", 32'(seq_len), 32'd3);
        run = 1'b1;
        step();
        want_frame("seq_a0", seq_a[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (TICK_DIV) step();
            want_frame("seq_a", seq_a[i]);
        end
        stop_run();

        // four beats without last, then a fifth with last
        beat(5'h03, 1'b0);
        beat(5'h04, 1'b0);
        beat(5'h05, 1'b0);
        beat(5'h06, 1'b0);
        chk("len4", 32'(seq_len), 32'd4);
        beat(5'h0A, 1'b1);
        chk("len1", 32'(seq_len), 32'd1);
        run = 1'b1;
        step();
        want_frame("len1_f0", 5'h0A);
        for (int i = 0; i < 3; i++) begin
            repeat (TICK_DIV) step();
            want_frame("len1_f", 5'h0A);
        end
        stop_run();

        // loads ignored while playing
        beat(5'h15, 1'b0);
        beat(5'h0C, 1'b0);
        beat(5'h07, 1'b1);
        run = 1'b1;
        step();
        want_frame("play_f0", 5'h15);
        load_valid = 1'b1;
        load_frame = 5'h1E;
        load_last  = 1'b1;
        repeat (TICK_DIV) step();
        chk("play_ready", 32'(load_ready), 32'd0);
        want_frame("play_f1", 5'h0C);
        repeat (TICK_DIV) step();
        want_frame("play_f2", 5'h07);
        load_valid = 1'b0;
        load_last  = 1'b0;
        stop_run();
        run = 1'b1;
        step();
        want_frame("restart_f0", 5'h15);

        // reset mid-run with run held
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_len", 32'(seq_len), 32'd0);
        chk("midrst_frame", 32'(frame_out), 32'd0);
        repeat (5) step();
        chk("midrst_idle", 32'(busy), 32'd0);
        run = 1'b0;
        step();

        // stop on the terminal-count edge
        beat(5'h11, 1'b0);
        beat(5'h12, 1'b1);
        run = 1'b1;
        step();
        want_frame("tc_f0", 5'h11);
        repeat (TICK_DIV - 1) step();
        run = 1'b0;
        step();
        want_frame("tc_blank", 5'h00);
        run = 1'b1;
        step();
        want_frame("tc_restart", 5'h11);
        run = 1'b0;
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 6) run = ~run;
            load_valid = 1'($urandom);
            load_frame = LED_W'($urandom);
            load_last  = ($urandom_range(0, 4) == 0);
            step();
        end
        rst        = 1'b0;
        run        = 1'b0;
        load_valid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
